// File: rtl/byte_data_mem.sv
// Byte-addressable RV32I data memory with byte-lane stores, sign/zero-extending loads and optional two-beat misaligned access.
// Load latency 1 (aligned) or 2 (split); stall is asserted only in the first cycle of a split access.
module byte_data_mem #(
   parameter int DEPTH_WORDS    = 256,
   parameter int ADDR_W         = 32,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic              stall,
   output logic              acc_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic {IDLE, BEAT2} state_t;

   state_t        state;
   logic [31:0]   mem [DEPTH_WORDS];

   logic [AW-1:0] lat_idx;
   logic [1:0]    lat_off;
   logic          lat_we;
   logic [2:0]    lat_f3;
   logic [31:0]   lat_wdata;
   logic [31:0]   hold;

   logic [AW-1:0] cur_idx;
   logic [1:0]    cur_off;
   logic [AW-1:0] next_idx;
   logic [AW-1:0] rd_idx;
   logic [31:0]   rd_word;
   logic [3:0]    cur_base;
   logic [3:0]    lat_base;
   logic [2:0]    lat_sh;
   logic          illegal;
   logic          misal;
   logic          reject;

   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [3:0]    wr_mask;
   logic [31:0]   wr_data;

   logic          unused_addr;
   assign unused_addr = ^addr[ADDR_W-1:AW+2];

   // Contiguous lane pattern for the access size, before shifting to the byte offset.
   function automatic logic [3:0] size_base(input logic [1:0] sz);
      case (sz)
         2'b00:   size_base = 4'b0001;
         2'b01:   size_base = 4'b0011;
         default: size_base = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] f, input logic [2:0] f3);
      case (f3)
         3'b000:  extend = {{24{f[7]}}, f[7:0]};
         3'b001:  extend = {{16{f[15]}}, f[15:0]};
         3'b100:  extend = {24'b0, f[7:0]};
         3'b101:  extend = {16'b0, f[15:0]};
         default: extend = f;
      endcase
   endfunction

   assign cur_idx  = addr[AW+1:2];
   assign cur_off  = addr[1:0];
   assign next_idx = lat_idx + AW'(1);
   assign rd_idx   = (state == BEAT2) ? next_idx : cur_idx;
   assign rd_word  = mem[rd_idx];
   assign cur_base = size_base(funct3[1:0]);
   assign lat_base = size_base(lat_f3[1:0]);
   // Number of bytes that came from the low word; upper-beat data shifts by this much.
   assign lat_sh   = 3'd4 - {1'b0, lat_off};

   assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
   assign misal   = ((funct3[1:0] == 2'b01) && (cur_off == 2'b11)) ||
                    ((funct3[1:0] == 2'b10) && (cur_off != 2'b00));
   assign reject  = illegal || (misal && !MISALIGN_SPLIT);
   assign stall   = (state == IDLE) && req && !reject && misal;

   // Truncating the shifted lane pattern yields lanes off..3 for the low beat of a split store.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = cur_idx;
      wr_mask = 4'b0000;
      wr_data = 32'b0;
      if (rst_n) begin
         if (state == BEAT2) begin
            if (lat_we) begin
               wr_en   = 1'b1;
               wr_idx  = next_idx;
               wr_mask = lat_base >> lat_sh;
               wr_data = lat_wdata >> {lat_sh, 3'b000};
            end
         end else if (req && we && !reject) begin
            wr_en   = 1'b1;
            wr_idx  = cur_idx;
            wr_mask = cur_base << cur_off;
            wr_data = wdata << {cur_off, 3'b000};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rdata     <= 32'b0;
         rvalid    <= 1'b0;
         acc_err   <= 1'b0;
         lat_idx   <= '0;
         lat_off   <= 2'b00;
         lat_we    <= 1'b0;
         lat_f3    <= 3'b000;
         lat_wdata <= 32'b0;
         hold      <= 32'b0;
      end else begin
         rvalid  <= 1'b0;
         acc_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (reject) begin
                     acc_err <= 1'b1;
                  end else if (misal) begin
                     state     <= BEAT2;
                     lat_idx   <= cur_idx;
                     lat_off   <= cur_off;
                     lat_we    <= we;
                     lat_f3    <= funct3;
                     lat_wdata <= wdata;
                     hold      <= rd_word >> {cur_off, 3'b000};
                  end else if (!we) begin
                     rdata  <= extend(rd_word >> {cur_off, 3'b000}, funct3);
                     rvalid <= 1'b1;
                  end
               end
            end
            BEAT2: begin
               state <= IDLE;
               if (!lat_we) begin
                  rdata  <= extend(hold | (rd_word << {lat_sh, 3'b000}), lat_f3);
                  rvalid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_data_mem.sv
// Directed bench for byte_data_mem: one split-mode and one reject-mode instance.
module tb_byte_data_mem;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_a, req_b, we;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [31:0] rdata_a, rdata_b;
   logic        rvalid_a, rvalid_b, stall_a, stall_b, acc_err_a, acc_err_b;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   byte_data_mem #(.DEPTH_WORDS(256), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_split (
      .clk(clk), .rst_n(rst_n), .req(req_a), .we(we), .funct3(funct3), .addr(addr),
      .wdata(wdata), .rdata(rdata_a), .rvalid(rvalid_a), .stall(stall_a), .acc_err(acc_err_a)
   );

   byte_data_mem #(.DEPTH_WORDS(256), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_rej (
      .clk(clk), .rst_n(rst_n), .req(req_b), .we(we), .funct3(funct3), .addr(addr),
      .wdata(wdata), .rdata(rdata_b), .rvalid(rvalid_b), .stall(stall_b), .acc_err(acc_err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   task automatic drive(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      we = w; funct3 = f; addr = a; wdata = d;
   endtask

   task automatic store_a(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, f, a, d); req_a = 1'b1;
      tick(); idle();
   endtask

   task automatic load_a(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
      drive(1'b0, f, a, 32'h0); req_a = 1'b1;
      tick(); idle();
      chk({tag, "_rvalid"}, 32'(rvalid_a), 32'd1);
      chk({tag, "_rdata"}, rdata_a, exp);
   endtask

   initial begin
      rst_n = 1'b0; idle(); drive(1'b0, 3'b010, 32'h0, 32'h0);
      tick(); tick();
      chk("rst_rdata", rdata_a, 32'h0);
      chk("rst_rvalid", 32'(rvalid_a), 32'd0);
      chk("rst_acc_err", 32'(acc_err_a), 32'd0);
      chk("rst_stall", 32'(stall_a), 32'd0);
      rst_n = 1'b1;
      tick();

      // aligned word store / load
      store_a(3'b010, 32'h10, 32'hDEADBEEF);
      load_a("lw10", 3'b010, 32'h10, 32'hDEADBEEF);
      tick();
      chk("rvalid_pulse", 32'(rvalid_a), 32'd0);

      // byte store and sign / zero extension
      store_a(3'b010, 32'h20, 32'hAABBCCDD);
      store_a(3'b000, 32'h21, 32'h00000080);
      load_a("lb21", 3'b000, 32'h21, 32'hFFFFFF80);
      load_a("lbu21", 3'b100, 32'h21, 32'h00000080);
      load_a("lw20", 3'b010, 32'h20, 32'hAABB80DD);
      load_a("lh22", 3'b001, 32'h22, 32'hFFFFAABB);

      // split misaligned store
      store_a(3'b010, 32'h0C, 32'h55667788);
      drive(1'b1, 3'b010, 32'h0E, 32'h11223344); req_a = 1'b1;
      #1 chk("sw0e_stall1", 32'(stall_a), 32'd1);
      tick();
      chk("sw0e_stall2", 32'(stall_a), 32'd0);
      tick(); idle();
      load_a("lw0c", 3'b010, 32'h0C, 32'h33447788);
      load_a("lw10b", 3'b010, 32'h10, 32'hDEAD1122);
      load_a("lhu0d", 3'b101, 32'h0D, 32'h00004477);

      // split misaligned load: 2-cycle latency
      drive(1'b0, 3'b010, 32'h0E, 32'h0); req_a = 1'b1;
      #1 chk("lw0e_stall", 32'(stall_a), 32'd1);
      tick();
      chk("lw0e_rvalid_early", 32'(rvalid_a), 32'd0);
      tick(); idle();
      chk("lw0e_rvalid", 32'(rvalid_a), 32'd1);
      chk("lw0e_rdata", rdata_a, 32'h11223344);

      // wrap at top of memory
      store_a(3'b010, 32'h3FC, 32'hAB000000);
      store_a(3'b010, 32'h000, 32'h000000C3);
      drive(1'b0, 3'b001, 32'h3FF, 32'h0); req_a = 1'b1;
      tick(); tick(); idle();
      chk("lh3ff", rdata_a, 32'hFFFFC3AB);
      drive(1'b0, 3'b101, 32'h3FF, 32'h0); req_a = 1'b1;
      tick(); tick(); idle();
      chk("lhu3ff", rdata_a, 32'h0000C3AB);

      // illegal store width on the split instance
      drive(1'b1, 3'b101, 32'h20, 32'hFFFFFFFF); req_a = 1'b1;
      tick(); idle();
      chk("shu_err", 32'(acc_err_a), 32'd1);
      chk("shu_rvalid", 32'(rvalid_a), 32'd0);
      load_a("shu_mem", 3'b010, 32'h20, 32'hAABB80DD);

      // reject-mode instance
      drive(1'b1, 3'b010, 32'h00, 32'h12345678); req_b = 1'b1;
      tick(); idle();
      drive(1'b0, 3'b010, 32'h00, 32'h0); req_b = 1'b1;
      tick(); idle();
      chk("b_lw0", rdata_b, 32'h12345678);
      drive(1'b0, 3'b010, 32'h02, 32'h0); req_b = 1'b1;
      #1 chk("b_lw2_stall", 32'(stall_b), 32'd0);
      tick(); idle();
      chk("b_lw2_err", 32'(acc_err_b), 32'd1);
      chk("b_lw2_rvalid", 32'(rvalid_b), 32'd0);
      chk("b_lw2_rdata", rdata_b, 32'h12345678);
      tick();
      chk("b_err_pulse", 32'(acc_err_b), 32'd0);
      drive(1'b1, 3'b011, 32'h00, 32'hFFFFFFFF); req_b = 1'b1;
      tick(); idle();
      chk("b_f3_011_err", 32'(acc_err_b), 32'd1);
      drive(1'b0, 3'b010, 32'h00, 32'h0); req_b = 1'b1;
      tick(); idle();
      chk("b_f3_011_mem", rdata_b, 32'h12345678);

      // reset during upper beat of split store
      store_a(3'b010, 32'h40, 32'h0);
      store_a(3'b010, 32'h44, 32'h0);
      drive(1'b1, 3'b010, 32'h41, 32'hCAFEBABE); req_a = 1'b1;
      tick();
      idle(); rst_n = 1'b0;
      tick();
      chk("rst2_rvalid", 32'(rvalid_a), 32'd0);
      chk("rst2_acc_err", 32'(acc_err_a), 32'd0);
      chk("rst2_stall", 32'(stall_a), 32'd0);
      chk("rst2_rdata", rdata_a, 32'h0);
      rst_n = 1'b1;
      tick();
      load_a("rst2_lw40", 3'b010, 32'h40, 32'hFEBABE00);
      load_a("rst2_lw44", 3'b010, 32'h44, 32'h00000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
